ysyx_24090018_alu_issue: RTL and testbench
==========================================

YSYX_24090018_ALU_ISSUE -- requirements
Module: ysyx_24090018_alu_issue

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/PC width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports in_valid in 1 and in_ready out 1: upstream (decode) handshake; a beat transfers when both are high at a clk edge.
REQ-005 SHALL have ports in_pc, in_rs1_data, in_rs2_data and in_imm, each in 32: PC, register operands and sign-extended immediate.
REQ-006 SHALL have ports in_opcode in 7, in_funct3 in 3, in_funct7_5 in 1 (instr[30]) and in_rd in 5: decoded instruction fields.
REQ-007 SHALL have port flush_i  in  1  discards all buffered beats.
REQ-008 SHALL have ports out_valid out 1 and out_ready in 1: downstream (ALU/EX) handshake.
REQ-009 SHALL have ports out_din1 out 32, out_din2 out 32 and out_alu_sel out 4: operands and ALU select.
REQ-010 SHALL have ports out_rd out 5 and out_illegal out 1: destination register and unsupported-op flag.

Function
REQ-011 SHALL encode alu_sel as 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, and 1111 for illegal.
REQ-012 SHALL decode OP (0110011) as din1=rs1, din2=rs2, with funct3 mapping:
  - 000: ADD, or SUB when funct7_5=1
  - 111: AND; 110: OR; 100: XOR; 001: SLL
  - 101: SRL, or SRA when funct7_5=1
REQ-013 SHALL decode OP-IMM (0010011) as din1=rs1, din2=imm, with the REQ-012 funct3 mapping, except that funct3=000 is always ADD (funct7_5 ignored).
REQ-014 SHALL decode the following as ADD:
  - LUI (0110111): din1=0, din2=imm
  - AUIPC (0010111): din1=pc, din2=imm
  - LOAD (0000011) / STORE (0100011): din1=rs1, din2=imm
  - JAL (1101111) / JALR (1100111): din1=pc, din2=32'd4
REQ-015 SHALL treat funct3 010/011 under OP/OP-IMM, and any other opcode, as illegal:
  - alu_sel=1111, din1=din2=0, out_illegal=1
  - the beat is still forwarded
REQ-016 SHALL set out_illegal=0 for every legal beat.
REQ-017 SHALL compute decode combinationally from in_* and register the result; no arithmetic is performed in this block.
REQ-018 SHALL hold two entries, main (drives out_*) and skid.
REQ-019 SHALL drive in_ready = NOT skid_valid, from a register, with no combinational path from out_ready.
REQ-020 SHALL have a latency of exactly 1 cycle: a beat accepted at edge N appears on out_* after edge N when main was empty or drained at N.
REQ-021 SHALL sustain throughput of 1 beat/cycle while out_ready stays high.
REQ-022 SHALL, on accept while main is occupied and not draining, store the beat into skid and deassert in_ready the next cycle.
REQ-023 SHALL, when main drains and skid is valid, move skid into main and clear skid in the same edge.
REQ-024 SHALL keep out_* stable while out_valid=1 and out_ready=0.
REQ-025 SHALL deliver beats in acceptance order, with none lost or duplicated.
REQ-026 SHALL, on flush_i=1 at an edge:
  - clear main_valid and skid_valid
  - drop any beat offered that cycle
  - drive in_ready=1 and out_valid=0 the next cycle
REQ-027 SHALL give flush_i priority over simultaneous accept and drain.

Reset
REQ-028 SHALL, while rst=1, immediately drive out_valid=0, in_ready=0, out_din1=out_din2=0, out_alu_sel=0000, out_rd=0 and out_illegal=0.
REQ-029 SHALL drive in_ready=1 at the first clk edge after rst deasserts, with both entries empty.
REQ-030 SHALL discard in-flight beats on rst asserted mid-operation; none appear after release.

Verification
REQ-031 SHALL cover: OP add, rs1=5, rs2=3, funct7_5=0, out_ready=1 -> next cycle out_valid=1, din1=5, din2=3, alu_sel=0010.
REQ-032 SHALL cover: OP-IMM funct3=101, funct7_5=1, imm=4; then AUIPC pc=0x80000000, imm=0x1000 -> sel 0111, din2=4; then sel 0010, din1=0x80000000, din2=0x1000.
REQ-033 SHALL cover: out_ready=0 with 3 beats offered -> 2 accepted, in_ready=0 after the 2nd; out_ready=1 for 2 cycles -> beats emerge in order and in_ready returns to 1.
REQ-034 SHALL cover: opcode 1110011 -> out_illegal=1, alu_sel=1111, din1=din2=0.
REQ-035 SHALL cover: both entries full and flush_i=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered beat never appears.
REQ-036 SHALL cover: rst pulsed asynchronously mid-stream -> outputs zero within the same cycle, in_ready=1 one edge after release, and no stale beat is delivered.

Source files
------------

// File: rtl/ysyx_24090018_alu_issue.sv
// ALU issue stage: decodes an RV32I ALU-class beat into operands and a select, then buffers
// it in a two-entry skid buffer (main + skid) so in_ready never depends on out_ready.
module ysyx_24090018_alu_issue #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_rs1_data,
   input  logic [DATA_W-1:0] in_rs2_data,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [6:0]        in_opcode,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7_5,
   input  logic [4:0]        in_rd,
   input  logic              flush_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_din1,
   output logic [DATA_W-1:0] out_din2,
   output logic [3:0]        out_alu_sel,
   output logic [4:0]        out_rd,
   output logic              out_illegal
);

   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0010;
   localparam logic [3:0] SEL_XOR = 4'b0011;
   localparam logic [3:0] SEL_SLL = 4'b0100;
   localparam logic [3:0] SEL_SRL = 4'b0101;
   localparam logic [3:0] SEL_SUB = 4'b0110;
   localparam logic [3:0] SEL_SRA = 4'b0111;
   localparam logic [3:0] SEL_ILL = 4'b1111;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};
   localparam logic [DATA_W-1:0] FOUR = {{(DATA_W-3){1'b0}}, 3'd4};

   typedef struct packed {
      logic              illegal;
      logic [4:0]        rd;
      logic [3:0]        sel;
      logic [DATA_W-1:0] din2;
      logic [DATA_W-1:0] din1;
   } entry_t;

   localparam entry_t ENTRY_ZERO = '{illegal: 1'b0, rd: 5'd0, sel: 4'd0, din2: ZERO, din1: ZERO};

   // Returns {legal, sel}; funct7_5 only qualifies ADD/SUB for register-register ops.
   function automatic logic [4:0] map_funct3(input logic [2:0] f3, input logic f75,
                                             input logic is_imm);
      logic [4:0] r;
      case (f3)
         3'b000:  r = {1'b1, (f75 && !is_imm) ? SEL_SUB : SEL_ADD};
         3'b111:  r = {1'b1, SEL_AND};
         3'b110:  r = {1'b1, SEL_OR};
         3'b100:  r = {1'b1, SEL_XOR};
         3'b001:  r = {1'b1, SEL_SLL};
         3'b101:  r = {1'b1, f75 ? SEL_SRA : SEL_SRL};
         default: r = {1'b0, SEL_ILL};
      endcase
      return r;
   endfunction

   entry_t     dec_s;
   logic [4:0] f3_map_s;

   entry_t     main_r;
   entry_t     skid_r;
   logic       main_valid_r;
   logic       skid_valid_r;
   logic       in_ready_r;
   logic       accept_s;
   logic       drain_s;

   // Combinational decode of the offered beat; illegal beats carry zero operands.
   always_comb begin
      dec_s    = ENTRY_ZERO;
      dec_s.rd = in_rd;
      f3_map_s = map_funct3(in_funct3, in_funct7_5, in_opcode == OPC_OP_IMM);
      dec_s.sel     = SEL_ILL;
      dec_s.illegal = 1'b1;
      case (in_opcode)
         OPC_OP, OPC_OP_IMM: begin
            if (f3_map_s[4]) begin
               dec_s.din1    = in_rs1_data;
               dec_s.din2    = (in_opcode == OPC_OP) ? in_rs2_data : in_imm;
               dec_s.sel     = f3_map_s[3:0];
               dec_s.illegal = 1'b0;
            end else begin
               dec_s.sel     = SEL_ILL;
               dec_s.illegal = 1'b1;
            end
         end
         OPC_LUI: begin
            dec_s.din2    = in_imm;
            dec_s.sel     = SEL_ADD;
            dec_s.illegal = 1'b0;
         end
         OPC_AUIPC: begin
            dec_s.din1    = in_pc;
            dec_s.din2    = in_imm;
            dec_s.sel     = SEL_ADD;
            dec_s.illegal = 1'b0;
         end
         OPC_LOAD, OPC_STORE: begin
            dec_s.din1    = in_rs1_data;
            dec_s.din2    = in_imm;
            dec_s.sel     = SEL_ADD;
            dec_s.illegal = 1'b0;
         end
         OPC_JAL, OPC_JALR: begin
            dec_s.din1    = in_pc;
            dec_s.din2    = FOUR;
            dec_s.sel     = SEL_ADD;
            dec_s.illegal = 1'b0;
         end
         default: begin
            dec_s.sel     = SEL_ILL;
            dec_s.illegal = 1'b1;
         end
      endcase
   end

   assign accept_s = in_valid && in_ready_r;
   assign drain_s  = main_valid_r && out_ready;

   // Skid buffer state; flush outranks accept and drain. Skid is only ever loaded while
   // in_ready is high, so it cannot be refilled in the cycle it empties into main.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_r       <= ENTRY_ZERO;
         skid_r       <= ENTRY_ZERO;
         main_valid_r <= 1'b0;
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b0;
      end else if (flush_i) begin
         main_valid_r <= 1'b0;
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b1;
      end else if (!main_valid_r || drain_s) begin
         if (skid_valid_r) begin
            main_r       <= skid_r;
            main_valid_r <= 1'b1;
            skid_valid_r <= 1'b0;
         end else if (accept_s) begin
            main_r       <= dec_s;
            main_valid_r <= 1'b1;
         end else begin
            main_valid_r <= 1'b0;
         end
         in_ready_r <= 1'b1;
      end else if (accept_s) begin
         skid_r       <= dec_s;
         skid_valid_r <= 1'b1;
         in_ready_r   <= 1'b0;
      end else begin
         in_ready_r <= !skid_valid_r;
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = main_valid_r;
   assign out_din1    = main_r.din1;
   assign out_din2    = main_r.din2;
   assign out_alu_sel = main_r.sel;
   assign out_rd      = main_r.rd;
   assign out_illegal = main_r.illegal;

endmodule

// File: tb/tb_ysyx_24090018_alu_issue.sv
// Directed self-checking bench for ysyx_24090018_alu_issue: decode vectors, back-pressure,
// flush and asynchronous reset, all with hand-computed expectations.
module tb_ysyx_24090018_alu_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic        in_funct7_5;
   logic [4:0]  in_rd;
   logic        flush_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_din1, out_din2;
   logic [3:0]  out_alu_sel;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int checks   = 0;
   int failures = 0;

   ysyx_24090018_alu_issue #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_rd(in_rd),
      .flush_i(flush_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_din1(out_din1), .out_din2(out_din2), .out_alu_sel(out_alu_sel),
      .out_rd(out_rd), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Checks a full output beat: valid, operands, select, rd, illegal.
   task automatic check_out(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [3:0] sel, input logic [4:0] rd, input logic ill);
      check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".din1"}, out_din1, d1);
      check({tag, ".din2"}, out_din2, d2);
      check({tag, ".sel"}, {28'd0, out_alu_sel}, {28'd0, sel});
      check({tag, ".rd"}, {27'd0, out_rd}, {27'd0, rd});
      check({tag, ".ill"}, {31'd0, out_illegal}, {31'd0, ill});
   endtask

   task automatic offer(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm);
      in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_funct7_5 = f75; in_rd = rd;
      in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b1;
      in_pc = 32'd0; in_rs1_data = 32'd0; in_rs2_data = 32'd0; in_imm = 32'd0;
      in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7_5 = 1'b0; in_rd = 5'd0;
      #12;
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.in_ready", {31'd0, in_ready}, 32'd0);
      check("rst.din1", out_din1, 32'd0);
      check("rst.sel", {28'd0, out_alu_sel}, 32'd0);
      #10 rst = 1'b0;
      step();
      check("rel.in_ready", {31'd0, in_ready}, 32'd1);
      check("rel.out_valid", {31'd0, out_valid}, 32'd0);

      // Back-to-back decode vectors with out_ready held high.
      offer(7'b0110011, 3'b000, 1'b0, 5'd1, 32'h0, 32'd5, 32'd3, 32'd0);
      step(); check_out("add", 32'd5, 32'd3, 4'b0010, 5'd1, 1'b0);
      offer(7'b0010011, 3'b101, 1'b1, 5'd2, 32'h0, 32'h80, 32'd9, 32'd4);
      step(); check_out("srai", 32'h80, 32'd4, 4'b0111, 5'd2, 1'b0);
      offer(7'b0010111, 3'b000, 1'b0, 5'd3, 32'h80000000, 32'd7, 32'd7, 32'h1000);
      step(); check_out("auipc", 32'h80000000, 32'h1000, 4'b0010, 5'd3, 1'b0);
      offer(7'b0110011, 3'b000, 1'b1, 5'd4, 32'h0, 32'd10, 32'd6, 32'd0);
      step(); check_out("sub", 32'd10, 32'd6, 4'b0110, 5'd4, 1'b0);
      offer(7'b0010011, 3'b000, 1'b1, 5'd5, 32'h0, 32'd1, 32'd2, 32'hFFFFFFFF);
      step(); check_out("addi_f75", 32'd1, 32'hFFFFFFFF, 4'b0010, 5'd5, 1'b0);
      offer(7'b0110011, 3'b101, 1'b0, 5'd6, 32'h0, 32'hF0, 32'd4, 32'd0);
      step(); check_out("srl", 32'hF0, 32'd4, 4'b0101, 5'd6, 1'b0);
      offer(7'b0110011, 3'b110, 1'b0, 5'd7, 32'h0, 32'hA, 32'h5, 32'd0);
      step(); check_out("or", 32'hA, 32'h5, 4'b0001, 5'd7, 1'b0);
      offer(7'b0010011, 3'b100, 1'b0, 5'd8, 32'h0, 32'hC, 32'h1, 32'h3);
      step(); check_out("xori", 32'hC, 32'h3, 4'b0011, 5'd8, 1'b0);
      offer(7'b0010011, 3'b001, 1'b0, 5'd9, 32'h0, 32'h1, 32'h1, 32'h2);
      step(); check_out("slli", 32'h1, 32'h2, 4'b0100, 5'd9, 1'b0);
      offer(7'b0110011, 3'b111, 1'b0, 5'd10, 32'h0, 32'hFF, 32'h0F, 32'd0);
      step(); check_out("and", 32'hFF, 32'h0F, 4'b0000, 5'd10, 1'b0);
      offer(7'b0110111, 3'b000, 1'b0, 5'd11, 32'h100, 32'h55, 32'h66, 32'h12345000);
      step(); check_out("lui", 32'h0, 32'h12345000, 4'b0010, 5'd11, 1'b0);
      offer(7'b1101111, 3'b000, 1'b0, 5'd12, 32'h200, 32'h55, 32'h66, 32'h40);
      step(); check_out("jal", 32'h200, 32'd4, 4'b0010, 5'd12, 1'b0);
      offer(7'b0100011, 3'b010, 1'b0, 5'd13, 32'h200, 32'h1000, 32'h66, 32'h8);
      step(); check_out("store", 32'h1000, 32'h8, 4'b0010, 5'd13, 1'b0);
      offer(7'b1110011, 3'b000, 1'b0, 5'd14, 32'h300, 32'h11, 32'h22, 32'h33);
      step(); check_out("system", 32'h0, 32'h0, 4'b1111, 5'd14, 1'b1);
      offer(7'b0110011, 3'b010, 1'b0, 5'd15, 32'h0, 32'h11, 32'h22, 32'h0);
      step(); check_out("slt", 32'h0, 32'h0, 4'b1111, 5'd15, 1'b1);
      idle();
      step(); check("drain.out_valid", {31'd0, out_valid}, 32'd0);

      // Back-pressure: three beats offered, only two taken.
      out_ready = 1'b0;
      offer(7'b0110011, 3'b000, 1'b0, 5'd21, 32'h0, 32'd21, 32'd1, 32'd0);
      step(); check("bp1.in_ready", {31'd0, in_ready}, 32'd1);
      offer(7'b0110011, 3'b000, 1'b0, 5'd22, 32'h0, 32'd22, 32'd1, 32'd0);
      step(); check("bp2.in_ready", {31'd0, in_ready}, 32'd0);
      offer(7'b0110011, 3'b000, 1'b0, 5'd23, 32'h0, 32'd23, 32'd1, 32'd0);
      step(); check_out("bp_hold", 32'd21, 32'd1, 4'b0010, 5'd21, 1'b0);
      check("bp3.in_ready", {31'd0, in_ready}, 32'd0);
      idle(); out_ready = 1'b1;
      step(); check_out("bp_second", 32'd22, 32'd1, 4'b0010, 5'd22, 1'b0);
      check("bp4.in_ready", {31'd0, in_ready}, 32'd1);
      step(); check("bp_empty.out_valid", {31'd0, out_valid}, 32'd0);

      // Flush with both entries full and a beat on the input.
      out_ready = 1'b0;
      offer(7'b0110011, 3'b000, 1'b0, 5'd1, 32'h0, 32'd31, 32'd1, 32'd0);
      step();
      offer(7'b0110011, 3'b000, 1'b0, 5'd2, 32'h0, 32'd32, 32'd1, 32'd0);
      step();
      offer(7'b0110011, 3'b000, 1'b0, 5'd3, 32'h0, 32'd33, 32'd1, 32'd0);
      flush_i = 1'b1;
      step(); flush_i = 1'b0; idle(); out_ready = 1'b1;
      check("fl.out_valid", {31'd0, out_valid}, 32'd0);
      check("fl.in_ready", {31'd0, in_ready}, 32'd1);
      step(); check("fl_after1.out_valid", {31'd0, out_valid}, 32'd0);
      step(); check("fl_after2.out_valid", {31'd0, out_valid}, 32'd0);

      // Flush while in_ready=1 must drop the offered beat too.
      out_ready = 1'b0;
      offer(7'b0110011, 3'b000, 1'b0, 5'd4, 32'h0, 32'd41, 32'd1, 32'd0);
      step();
      offer(7'b0110011, 3'b000, 1'b0, 5'd5, 32'h0, 32'd42, 32'd1, 32'd0);
      flush_i = 1'b1;
      step(); flush_i = 1'b0; idle(); out_ready = 1'b1;
      check("fl2.out_valid", {31'd0, out_valid}, 32'd0);
      step(); check("fl2_after.out_valid", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset in the middle of a stalled stream.
      out_ready = 1'b0;
      offer(7'b0110011, 3'b000, 1'b0, 5'd6, 32'h0, 32'd51, 32'd1, 32'd0);
      step();
      offer(7'b0110011, 3'b000, 1'b0, 5'd7, 32'h0, 32'd52, 32'd1, 32'd0);
      step(); idle();
      #2 rst = 1'b1;
      #1;
      check("arst.out_valid", {31'd0, out_valid}, 32'd0);
      check("arst.in_ready", {31'd0, in_ready}, 32'd0);
      check("arst.din1", out_din1, 32'd0);
      check("arst.rd", {27'd0, out_rd}, 32'd0);
      step();
      #2 rst = 1'b0; out_ready = 1'b1;
      step();
      check("arst_rel.in_ready", {31'd0, in_ready}, 32'd1);
      check("arst_rel.out_valid", {31'd0, out_valid}, 32'd0);
      step(); check("arst_stale.out_valid", {31'd0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
